// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and default constants for the instruction fetch stage.
package instr_fetch_unit_pkg;

  localparam int          IFU_ADDR_W      = 8;
  localparam int          IFU_DATA_W      = 8;
  localparam logic [7:0]  IFU_RESET_PC    = 8'h00;
  localparam logic [7:0]  IFU_HALT_OPCODE = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FETCH = 2'd2,
    ST_HALT  = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction memory port: the fetch unit drives it, the memory answers.
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);

  logic              imem_read;
  logic              imem_write;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_wdata;
  logic [DATA_W-1:0] imem_rdata;

  modport master (
    output imem_read,
    output imem_write,
    output imem_addr,
    output imem_wdata,
    input  imem_rdata
  );

  modport slave (
    input  imem_read,
    input  imem_write,
    input  imem_addr,
    input  imem_wdata,
    output imem_rdata
  );

endinterface

// File: rtl/instr_fetch_unit_pc_reg.sv
// Program counter: load (branch / restart) beats increment; neither means hold.
module instr_fetch_unit_pc_reg #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] reset_pc_i,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] load_val_i,
  input  logic              inc_i,
  output logic [ADDR_W-1:0] pc_o
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = load_val_i;
    end else if (inc_i) begin
      pc_d = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= reset_pc_i;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: boot loader into instruction memory, then PC-driven fetch
// with a one-cycle registered instruction output and halt detection.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int                ADDR_W      = IFU_ADDR_W,
  parameter int                DATA_W      = IFU_DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC    = ADDR_W'(IFU_RESET_PC),
  parameter logic [DATA_W-1:0] HALT_OPCODE = DATA_W'(IFU_HALT_OPCODE)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      load_en_i,
  input  logic                      load_valid_i,
  input  logic [DATA_W-1:0]         load_data_i,
  output logic                      load_ready_o,
  input  logic                      start_i,
  input  logic                      stall_i,
  input  logic                      branch_taken_i,
  input  logic [ADDR_W-1:0]         branch_target_i,
  instr_fetch_unit_if.master        imem,
  output logic [DATA_W-1:0]         instr_o,
  output logic [ADDR_W-1:0]         instr_pc_o,
  output logic                      instr_valid_o,
  output logic                      halted_o
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] load_ptr_q, load_ptr_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
  logic              instr_valid_q, instr_valid_d;

  logic [ADDR_W-1:0] pc;
  logic              pc_load;
  logic [ADDR_W-1:0] pc_load_val;
  logic              pc_inc;

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic              load_ready;

  instr_fetch_unit_pc_reg #(.ADDR_W(ADDR_W)) u_pc_reg (
    .clk        (clk),
    .reset      (reset),
    .reset_pc_i (RESET_PC),
    .load_i     (pc_load),
    .load_val_i (pc_load_val),
    .inc_i      (pc_inc),
    .pc_o       (pc)
  );

  always_comb begin
    state_d       = state_q;
    load_ptr_d    = load_ptr_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    pc_load       = 1'b0;
    pc_load_val   = RESET_PC;
    pc_inc        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_addr      = pc;
    load_ready    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (load_en_i) begin
          state_d    = ST_LOAD;
          load_ptr_d = '0;
        end else if (start_i) begin
          state_d = ST_FETCH;
          pc_load = 1'b1;
        end
      end

      ST_LOAD: begin
        mem_addr      = load_ptr_q;
        instr_valid_d = 1'b0;
        // A byte offered on the cycle load_en drops is deliberately not stored.
        if (load_en_i) begin
          load_ready = 1'b1;
          mem_write  = load_valid_i;
          if (load_valid_i) begin
            load_ptr_d = load_ptr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
          end
        end else begin
          state_d = ST_IDLE;
          pc_load = 1'b1;
        end
      end

      ST_FETCH: begin
        mem_read = 1'b1;
        if (branch_taken_i) begin
          pc_load       = 1'b1;
          pc_load_val   = branch_target_i;
          instr_valid_d = 1'b0;
        end else if (!stall_i) begin
          instr_d       = imem.imem_rdata;
          instr_pc_d    = pc;
          instr_valid_d = 1'b1;
          // The halt byte is still handed to decode; the PC parks on it.
          if (imem.imem_rdata == HALT_OPCODE) begin
            state_d = ST_HALT;
          end else begin
            pc_inc = 1'b1;
          end
        end
      end

      ST_HALT: begin
        instr_valid_d = 1'b0;
        if (load_en_i) begin
          state_d    = ST_LOAD;
          load_ptr_d = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      load_ptr_q    <= '0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      load_ptr_q    <= load_ptr_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  assign imem.imem_read  = mem_read;
  assign imem.imem_write = mem_write;
  assign imem.imem_addr  = mem_addr;
  assign imem.imem_wdata = load_data_i;

  assign load_ready_o  = load_ready;
  assign instr_o       = instr_q;
  assign instr_pc_o    = instr_pc_q;
  assign instr_valid_o = instr_valid_q;
  assign halted_o      = (state_q == ST_HALT);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a behavioural instruction memory.
module tb_instr_fetch_unit;

  logic       clk;
  logic       reset;
  logic       load_en;
  logic       load_valid;
  logic [7:0] load_data;
  logic       load_ready;
  logic       start;
  logic       stall;
  logic       branch_taken;
  logic [7:0] branch_target;
  logic [7:0] instr;
  logic [7:0] instr_pc;
  logic       instr_valid;
  logic       halted;

  instr_fetch_unit_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  instr_fetch_unit dut (
    .clk             (clk),
    .reset           (reset),
    .load_en_i       (load_en),
    .load_valid_i    (load_valid),
    .load_data_i     (load_data),
    .load_ready_o    (load_ready),
    .start_i         (start),
    .stall_i         (stall),
    .branch_taken_i  (branch_taken),
    .branch_target_i (branch_target),
    .imem            (bus),
    .instr_o         (instr),
    .instr_pc_o      (instr_pc),
    .instr_valid_o   (instr_valid),
    .halted_o        (halted)
  );

  // Instruction_Memory: synchronous write, combinational read.
  logic [7:0] mem [256];
  always @(posedge clk) begin
    if (bus.imem_write) mem[bus.imem_addr] <= bus.imem_wdata;
  end
  assign bus.imem_rdata = mem[bus.imem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_instr(input string tag, input logic [7:0] d, input logic [7:0] pc);
    chk({tag, ".valid"}, 32'(instr_valid), 32'd1);
    chk({tag, ".instr"}, 32'(instr), 32'(d));
    chk({tag, ".pc"},    32'(instr_pc), 32'(pc));
  endtask

  // From HALT: pass through LOAD without writing, then start fetching at 0.
  task automatic restart();
    load_en = 1'b1; tick();
    load_en = 1'b0; tick();
    start   = 1'b1; tick();
    start   = 1'b0;
  endtask

  logic [7:0] prog [4] = '{8'h11, 8'h22, 8'h33, 8'hFF};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; load_en = 1'b0; load_valid = 1'b0; load_data = 8'h00;
    start = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 8'h00;
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("rst.instr",      32'(instr), 32'h0);
    chk("rst.instr_pc",   32'(instr_pc), 32'h0);
    chk("rst.valid",      32'(instr_valid), 32'd0);
    chk("rst.halted",     32'(halted), 32'd0);
    chk("rst.load_ready", 32'(load_ready), 32'd0);
    chk("rst.imem_read",  32'(bus.imem_read), 32'd0);
    chk("rst.imem_write", 32'(bus.imem_write), 32'd0);

    // Load 11 22 33 FF and run to halt.
    load_en = 1'b1; tick();
    chk("load.ready", 32'(load_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      load_valid = 1'b1; load_data = prog[i]; #1;
      chk("load.write", 32'(bus.imem_write), 32'd1);
      chk("load.addr",  32'(bus.imem_addr), 32'(i));
      tick();
    end
    load_valid = 1'b0; load_en = 1'b0; tick();
    chk("load.ready_idle", 32'(load_ready), 32'd0);
    for (int i = 0; i < 4; i++) chk("load.mem", 32'(mem[i]), 32'(prog[i]));
    start = 1'b1; tick(); start = 1'b0;
    chk("fetch.read", 32'(bus.imem_read), 32'd1);
    chk("fetch.addr", 32'(bus.imem_addr), 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_instr("run", prog[i], 8'(i));
      chk("run.halted", 32'(halted), (i == 3) ? 32'd1 : 32'd0);
    end
    tick();
    chk("halt.valid",  32'(instr_valid), 32'd0);
    chk("halt.halted", 32'(halted), 32'd1);
    chk("halt.read",   32'(bus.imem_read), 32'd0);

    // Stall three cycles with pc=2.
    restart();
    tick(); chk_instr("st.a", 8'h11, 8'h00);
    tick(); chk_instr("st.b", 8'h22, 8'h01);
    stall = 1'b1;
    repeat (3) begin
      tick(); chk_instr("st.hold", 8'h22, 8'h01);
    end
    stall = 1'b0;
    tick(); chk_instr("st.rel", 8'h33, 8'h02);
    tick(); chk_instr("st.ff", 8'hFF, 8'h03);
    tick(); chk("st.halted", 32'(halted), 32'd1);

    // Branch to 0 at pc=3 with stall also high.
    restart();
    tick(); chk_instr("br.a", 8'h11, 8'h00);
    tick(); chk_instr("br.b", 8'h22, 8'h01);
    tick(); chk_instr("br.c", 8'h33, 8'h02);
    branch_taken = 1'b1; branch_target = 8'h00; stall = 1'b1;
    tick(); chk("br.bubble", 32'(instr_valid), 32'd0);
    branch_taken = 1'b0; stall = 1'b0;
    tick(); chk_instr("br.tgt", 8'h11, 8'h00);
    tick(); chk_instr("br.next", 8'h22, 8'h01);
    tick(); tick(); tick();
    chk("br.halted", 32'(halted), 32'd1);

    // Stream 257 bytes: address 0 gets 77 then is overwritten with 00.
    load_en = 1'b1; tick();
    for (int i = 0; i < 257; i++) begin
      load_valid = 1'b1; load_data = (i == 0) ? 8'h77 : 8'h00; #1;
      chk("s257.ready", 32'(load_ready), 32'd1);
      chk("s257.addr",  32'(bus.imem_addr), 32'(i & 255));
      tick();
      if (i == 0) chk("s257.first", 32'(mem[0]), 32'h77);
    end
    load_valid = 1'b0;
    chk("s257.wrap", 32'(mem[0]), 32'h00);
    load_en = 1'b0; tick();
    start = 1'b1; tick(); start = 1'b0;

    // All-zero memory: instr_pc walks 0..255 and wraps without a bubble.
    for (int k = 0; k < 256; k++) begin
      tick(); chk_instr("walk", 8'h00, 8'(k));
    end
    tick(); chk_instr("walk.wrap", 8'h00, 8'h00);

    // load_en and start are ignored while fetching.
    load_en = 1'b1; start = 1'b1; load_valid = 1'b1; load_data = 8'h99; #1;
    chk("ign.write", 32'(bus.imem_write), 32'd0);
    tick(); chk_instr("ign.instr", 8'h00, 8'h01);
    load_en = 1'b0; start = 1'b0; load_valid = 1'b0;
    chk("ign.read", 32'(bus.imem_read), 32'd1);

    // Reset mid-fetch at pc=5 with a distinctive program.
    reset = 1'b1; tick(); reset = 1'b0;
    load_en = 1'b1; tick();
    for (int i = 0; i < 8; i++) begin
      load_valid = 1'b1; load_data = 8'(i + 1); tick();
    end
    load_en = 1'b0; load_valid = 1'b1; load_data = 8'hEE; #1;
    chk("exit.write", 32'(bus.imem_write), 32'd0);
    tick(); load_valid = 1'b0;
    chk("exit.mem8", 32'(mem[8]), 32'h00);
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(); chk_instr("pre", 8'(i + 1), 8'(i));
    end
    reset = 1'b1; tick(); reset = 1'b0;
    chk("mrst.valid",  32'(instr_valid), 32'd0);
    chk("mrst.halted", 32'(halted), 32'd0);
    chk("mrst.read",   32'(bus.imem_read), 32'd0);
    chk("mrst.instr",  32'(instr), 32'h0);
    chk("mrst.pc",     32'(instr_pc), 32'h0);
    for (int i = 0; i < 8; i++) chk("mrst.mem", 32'(mem[i]), 32'(i + 1));
    start = 1'b1; tick(); start = 1'b0;
    tick(); chk_instr("post.a", 8'h01, 8'h00);
    tick(); chk_instr("post.b", 8'h02, 8'h01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
